// File: rtl/frame_mem_pkg.sv
// Shared frame-memory layout constants and the loader FSM state type.
// The VGA address generator imports the same constants so both sides agree on the layout.
package frame_mem_pkg;

    localparam int HDR_ADDR    = 2;
    localparam int ORIG_BASE   = 6;
    localparam int INTERP_BASE = 125016;
    localparam int MAX_DIM     = 400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_CHECK,
        S_HDR_WR,
        S_PIXEL,
        S_DONE,
        S_ERR
    } fsm_state_e;

endpackage

// File: rtl/frame_mem_writer_quad_dim_calc.sv
// Side length and pixel count of the image region selected by dest_sel.
// The interpolated quadrant has side 3*(dim/4)-2; a result <= 0 shows up as zero or bit 15 set.
module quad_dim_calc #(
    parameter int ADDR_W = 19
) (
    input  logic [15:0]       dim,
    input  logic              dest_sel,
    output logic [15:0]       side,
    output logic [ADDR_W-1:0] count
);

    logic [15:0] quarter;

    always_comb begin
        quarter = dim >> 2;
        side    = dest_sel ? (quarter * 16'd3) - 16'd2 : dim;
        count   = ADDR_W'({16'd0, side} * {16'd0, side});
    end

endmodule

// File: rtl/frame_mem_writer.sv
// Streams a dimension header plus row-major pixels into frame memory as single-word writes.
// Every output is registered; a pixel write appears one cycle after its handshake.
module frame_mem_writer
    import frame_mem_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dest_sel,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    fsm_state_e        state, next;
    logic              dest_q;
    logic [15:0]       dim;
    logic [15:0]       side;
    logic [ADDR_W-1:0] calc_count;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] count;
    logic              accept;
    logic              hdr_ok;

    quad_dim_calc #(.ADDR_W(ADDR_W)) u_calc (
        .dim      (dim),
        .dest_sel (dest_q),
        .side     (side),
        .count    (calc_count)
    );

    assign accept = in_valid && in_ready;
    assign hdr_ok = (dim != 16'd0) && (dim <= 16'(MAX_DIM)) && (side != 16'd0) && !side[15];

    always_comb begin
        next = state;
        case (state)
            S_IDLE:   if (start) next = S_HDR_HI;
            S_HDR_HI: if (accept) next = S_HDR_LO;
            S_HDR_LO: if (accept) next = S_CHECK;
            S_CHECK:  next = !hdr_ok ? S_ERR : (dest_q ? S_PIXEL : S_HDR_WR);
            S_HDR_WR: next = S_PIXEL;
            S_PIXEL:  if (accept && count == ADDR_W'(1)) next = S_DONE;
            S_DONE:   next = S_IDLE;
            S_ERR:    next = S_IDLE;
            default:  next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next;
    end

    // Status outputs are decoded from next so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dest_q    <= 1'b0;
            dim       <= '0;
            addr      <= '0;
            count     <= '0;
        end else begin
            in_ready <= (next == S_HDR_HI) || (next == S_HDR_LO) || (next == S_PIXEL);
            busy     <= (next != S_IDLE);
            done     <= (next == S_DONE);
            error    <= (next == S_ERR);
            mem_we   <= 1'b0;
            case (state)
                S_IDLE:   if (start) dest_q <= dest_sel;
                S_HDR_HI: if (accept) dim[15:8] <= in_data;
                S_HDR_LO: if (accept) dim[7:0] <= in_data;
                S_CHECK: begin
                    count <= calc_count;
                    addr  <= dest_q ? ADDR_W'(INTERP_BASE) : ADDR_W'(ORIG_BASE);
                    if (next == S_HDR_WR) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ADDR_W'(HDR_ADDR);
                        mem_wdata <= DATA_W'(dim);
                    end
                end
                S_PIXEL: if (accept) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr;
                    mem_wdata <= {{(DATA_W-8){1'b0}}, in_data};
                    addr      <= addr + ADDR_W'(1);
                    count     <= count - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_mem_writer.sv
// Directed bench for frame_mem_writer: a table of loads plus reset and restart corner cases.
module tb_frame_mem_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        dest_sel;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;

    frame_mem_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dest_sel  (dest_sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       dsel;
        logic [7:0] hi;
        logic [7:0] lo;
        int         npix;
        bit         stall;
        int         glitch;
        bit         exp_err;
        bit         exp_hdr;
        int         base;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    int wr_addr[$];
    int wr_data[$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int hs_miss  = 0;
    bit hs_prev  = 0;

    // Log writes and pulses mid-cycle; a pixel write must follow a handshake seen one cycle earlier.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(int'(mem_wdata));
            if (mem_addr != 19'd2 && !hs_prev) hs_miss++;
        end
        if (done)  done_cnt++;
        if (error) err_cnt++;
        hs_prev = in_valid && in_ready && rst_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        err_cnt  = 0;
        hs_miss  = 0;
    endtask

    task automatic push_byte(input string name, input logic [7:0] b, input bit stall);
        int guard = 0;
        if (stall) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk({name, " ready_timeout"}, 32'(guard), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic start_load(input logic dsel);
        start    = 1'b1;
        dest_sel = dsel;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({name, " busy_end"}, 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_and_check(input vec_t v);
        int exp_a[$];
        int exp_d[$];
        clear_log();
        start_load(v.dsel);
        push_byte(v.name, v.hi, v.stall);
        push_byte(v.name, v.lo, v.stall);
        if (!v.exp_err) begin
            for (int i = 0; i < v.npix; i++) begin
                if (i == v.glitch) start = 1'b1;
                push_byte(v.name, 8'(8'h10 + i), v.stall);
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
        wait_idle(v.name);

        if (!v.exp_err) begin
            if (v.exp_hdr) begin
                exp_a.push_back(2);
                exp_d.push_back(int'({v.hi, v.lo}));
            end
            for (int i = 0; i < v.npix; i++) begin
                exp_a.push_back(v.base + i);
                exp_d.push_back(16 + i);
            end
        end
        chk({v.name, " error_pulses"}, 32'(err_cnt), v.exp_err ? 32'd1 : 32'd0);
        chk({v.name, " done_pulses"}, 32'(done_cnt), v.exp_err ? 32'd0 : 32'd1);
        chk({v.name, " write_count"}, 32'(wr_addr.size()), 32'(exp_a.size()));
        chk({v.name, " late_writes"}, 32'(hs_miss), 32'd0);
        for (int i = 0; i < exp_a.size() && i < wr_addr.size(); i++) begin
            chk($sformatf("%s addr[%0d]", v.name, i), 32'(wr_addr[i]), 32'(exp_a[i]));
            chk($sformatf("%s data[%0d]", v.name, i), 32'(wr_data[i]), 32'(exp_d[i]));
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, " in_ready"},  32'(in_ready),  32'd0);
        chk({name, " mem_we"},    32'(mem_we),    32'd0);
        chk({name, " mem_addr"},  32'(mem_addr),  32'd0);
        chk({name, " mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({name, " busy"},      32'(busy),      32'd0);
        chk({name, " done"},      32'(done),      32'd0);
        chk({name, " error"},     32'(error),     32'd0);
    endtask

    vec_t vecs[8];
    vec_t after_rst;

    initial begin
        //              name         dsel hi     lo     npix stall glitch err  hdr base
        vecs[0] = '{"orig4x4",    1'b0, 8'h00, 8'h04, 16, 1'b0, -1, 1'b0, 1'b1, 6};
        vecs[1] = '{"interp8",    1'b1, 8'h00, 8'h08, 16, 1'b0, -1, 1'b0, 1'b0, 125016};
        vecs[2] = '{"stall4x4",   1'b0, 8'h00, 8'h04, 16, 1'b1, -1, 1'b0, 1'b1, 6};
        vecs[3] = '{"hdr_zero",   1'b0, 8'h00, 8'h00, 0,  1'b0, -1, 1'b1, 1'b0, 0};
        vecs[4] = '{"hdr_401",    1'b0, 8'h01, 8'h91, 0,  1'b0, -1, 1'b1, 1'b0, 0};
        vecs[5] = '{"interp_2",   1'b1, 8'h00, 8'h02, 0,  1'b0, -1, 1'b1, 1'b0, 0};
        vecs[6] = '{"orig1x1",    1'b0, 8'h00, 8'h01, 1,  1'b0, -1, 1'b0, 1'b1, 6};
        vecs[7] = '{"start_busy", 1'b0, 8'h00, 8'h04, 16, 1'b0, 3,  1'b0, 1'b1, 6};
        after_rst = '{"after_rst", 1'b0, 8'h00, 8'h02, 4, 1'b0, -1, 1'b0, 1'b1, 6};

        rst_n    = 1'b0;
        start    = 1'b0;
        dest_sel = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_and_check(vecs[i]);

        // Abandon a 4x4 load after five pixels; reset must clear outputs without waiting for a clock.
        clear_log();
        start_load(1'b0);
        push_byte("midrst", 8'h00, 1'b0);
        push_byte("midrst", 8'h04, 1'b0);
        for (int i = 0; i < 5; i++) push_byte("midrst", 8'(8'h10 + i), 1'b0);
        chk("midrst pre_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_log();
        repeat (5) @(posedge clk);
        #1;
        chk("midrst stray_writes", 32'(wr_addr.size()), 32'd0);
        run_and_check(after_rst);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_mem_writer.md
Name: frame_mem_writer

Overview:
- Loads an image into the shared frame memory that the VGA address generator reads.
- Accepts a byte stream (2-byte dimension header, then row-major 8-bit pixels) over a valid/ready handshake.
- Emits single-word memory writes in the layout the display path expects: dimension word at address 2, original image from address 6, interpolated quadrant from address 125016.
- Sits between the host/UART byte source and the frame memory write port.

Parameters:
- ADDR_W, 19, frame memory address width.
- DATA_W, 16, frame memory data width.
- HDR_ADDR, 2, address of the dimension word.
- ORIG_BASE, 6, first pixel address of the original image.
- INTERP_BASE, 125016, first pixel address of the interpolated quadrant.
- MAX_DIM, 400, largest accepted image side.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE
- dest_sel  in  1  latched at start; 0 = original image, 1 = interpolated quadrant
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts the byte this cycle
- mem_we  out  1  one-cycle memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- busy  out  1  high from the cycle after an accepted start until the return to IDLE
- done  out  1  one-cycle pulse after the last pixel write
- error  out  1  one-cycle pulse on a rejected header

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset acts immediately, including mid-load. A partially written image is abandoned and no further writes are issued.
- Handshake: a byte transfers when in_valid && in_ready are both high on a rising clk edge. in_ready is a registered FSM decode, high only in HDR_HI, HDR_LO and PIXEL. in_valid low simply stalls the FSM; no counter or state changes.
- FSM states and transitions:
  - IDLE: on start, latch dest_sel, go to HDR_HI. A start pulse in any other state is ignored.
  - HDR_HI: on accept, dim[15:8] <= byte, go to HDR_LO.
  - HDR_LO: on accept, dim[7:0] <= byte, go to CHECK.
  - CHECK (1 cycle):
    - If dim == 0 or dim > MAX_DIM: go to ERR.
    - Else side = dim when dest_sel = 0, or side = 3*(dim>>2) - 2 when dest_sel = 1. Computed in 16 bits.
    - If side == 0 (dest_sel = 1 with dim < 4 gives side <= 0): go to ERR.
    - Else count = side*side, truncated to ADDR_W, and addr <= base.
    - dest_sel = 0: go to HDR_WR.
    - dest_sel = 1: go to PIXEL. The header is not rewritten, so the original dimension word is preserved.
  - HDR_WR (1 cycle): mem_we = 1, mem_addr = HDR_ADDR, mem_wdata = dim. Go to PIXEL.
  - PIXEL: each accepted byte produces, on the next cycle, mem_we = 1, mem_addr = addr, mem_wdata = {8'h00, byte}. Then addr increments and count decrements. When the accepted byte is the last one (count == 1), go to DONE. The final write still issues.
  - DONE (1 cycle): done = 1, go to IDLE.
  - ERR (1 cycle): error = 1, go to IDLE. No memory write occurs.
- Latency: the memory write is registered and appears exactly 1 cycle after the handshake. Sustained throughput is 1 pixel per cycle.
- Addresses increase monotonically with no wrap-around. Checking dim against MAX_DIM guarantees INTERP_BASE + count < 2^ADDR_W.
- mem_addr and mem_wdata are don't-care when mem_we = 0; they hold their last value.

Decomposition:
- Package frame_mem_pkg holds:
  - the FSM state typedef;
  - the constants HDR_ADDR, ORIG_BASE, INTERP_BASE and MAX_DIM, which are shared with the VGA address generator so both agree on the memory layout.
- One sub-module, quad_dim_calc: combinational, computes side and count from dim and dest_sel. It is reused by the display side.

Test Plan:
- Original 4x4: dest_sel = 0, bytes 00 04 then 10..1F -> write (2, 0x0004), then pixel writes to addr 6..21 with data 0x0010..0x001F. done pulses once; busy then drops.
- Interpolated: dest_sel = 1, header 00 08 -> side = 4; 16 pixel writes at 125016..125031; no write to addr 2.
- Backpressure: same as the 4x4 case with in_valid low on alternate cycles -> identical write sequence; every write lands 1 cycle after its handshake.
- Header errors: header 00 00, header 01 91 (401), and header 00 02 with dest_sel = 1 -> error pulses once each, no mem_we, return to IDLE.
- Reset mid-load: assert rst_n = 0 after 5 pixels -> all outputs 0 immediately. A new 2x2 load then writes addr 2 and addr 6..9 correctly.
- Start while busy: pulse start during PIXEL -> ignored; the load completes with the original count.
